multi_edge_detect: RTL and testbench

Parametrised, multi-channel edge detector for asynchronous input signals. Each channel has a configurable-depth synchroniser, a consecutive-sample debounce filter, one-cycle rising and falling edge pulses, and a sticky, maskable pending flag with per-channel clear. The pending flags are ORed into a single interrupt request. The block sits between raw board inputs (keys, external strobes) and the control logic or interrupt aggregator.

---
 rtl/edge_pkg.sv | 15 +
 rtl/edge_chan.sv | 75 +++++++
 rtl/multi_edge_detect.sv | 43 ++++
 tb/tb_multi_edge_detect.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared constants and helpers for the multi-channel edge detector.
// Holds the default synchroniser/debounce depths and the counter-width function.
package edge_pkg;

    localparam int EDGE_SYNC_DEF = 2;
    localparam int EDGE_DEB_DEF  = 1;

    // A one-cycle filter still needs a 1-bit counter so the datapath stays uniform.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: synchroniser, debounce filter, edge pulses, sticky pending bit.
// Edge pulse SYNC_STAGES+DEBOUNCE_CYC-1 cycles after the input change, pending one later; no backpressure.
module edge_chan
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES  = EDGE_SYNC_DEF,
    parameter int DEBOUNCE_CYC = EDGE_DEB_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic signal,
    input  logic en_pos,
    input  logic en_neg,
    input  logic clr,
    output logic level,
    output logic pos_edge,
    output logic neg_edge,
    output logic pending
);

    localparam int              CW      = clog2_min1(DEBOUNCE_CYC);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nxt;
    logic                   level_nxt;
    logic                   pend_set;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], signal};
        end
    end

    // The counter only runs while the synced input disagrees with the accepted level,
    // so any return to the old level restarts the qualification window.
    always_comb begin
        level_nxt = level;
        cnt_nxt   = '0;
        if (sync != level) begin
            if (cnt == CNT_MAX) begin
                level_nxt = sync;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    assign pend_set = (pos_edge & en_pos) | (neg_edge & en_neg);

    always_ff @(posedge clk) begin
        if (rst) begin
            level    <= 1'b0;
            cnt      <= '0;
            pos_edge <= 1'b0;
            neg_edge <= 1'b0;
            pending  <= 1'b0;
        end else begin
            level    <= level_nxt;
            cnt      <= cnt_nxt;
            pos_edge <= ~level & level_nxt;
            neg_edge <= level & ~level_nxt;
            pending  <= pend_set | (pending & ~clr);
        end
    end

    a_one_edge: assert property (@(posedge clk) disable iff (rst) !(pos_edge && neg_edge));

endmodule

// File: rtl/multi_edge_detect.sv
// CH independent edge-detect channels with an OR-reduced interrupt request.
// Same latency as edge_chan per channel, irq combinational from pending; no backpressure.
module multi_edge_detect
    import edge_pkg::*;
#(
    parameter int CH           = 4,
    parameter int SYNC_STAGES  = EDGE_SYNC_DEF,
    parameter int DEBOUNCE_CYC = EDGE_DEB_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] signal,
    input  logic [CH-1:0] en_pos,
    input  logic [CH-1:0] en_neg,
    input  logic [CH-1:0] clr,
    output logic [CH-1:0] level,
    output logic [CH-1:0] pos_edge,
    output logic [CH-1:0] neg_edge,
    output logic [CH-1:0] pending,
    output logic          irq
);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .signal   (signal[i]),
            .en_pos   (en_pos[i]),
            .en_neg   (en_neg[i]),
            .clr      (clr[i]),
            .level    (level[i]),
            .pos_edge (pos_edge[i]),
            .neg_edge (neg_edge[i]),
            .pending  (pending[i])
        );
    end

    assign irq = |pending;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Bench for multi_edge_detect: one instance without filtering, one with a 4-cycle debounce.
// Expected edge events are queued when inputs are driven and matched as pulses appear.
module tb_multi_edge_detect;

    localparam int CH = 4;
    localparam int S  = 2;
    localparam int DA = 1;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic [CH-1:0] sig_a    = '0;
    logic [CH-1:0] en_pos_a = '1;
    logic [CH-1:0] en_neg_a = '1;
    logic [CH-1:0] clr_a    = '0;
    logic [CH-1:0] lvl_a, pos_a, neg_a, pend_a;
    logic          irq_a;

    logic [CH-1:0] sig_b    = '0;
    logic [CH-1:0] en_pos_b = '1;
    logic [CH-1:0] en_neg_b = '1;
    logic [CH-1:0] clr_b    = '0;
    logic [CH-1:0] lvl_b, pos_b, neg_b, pend_b;
    logic          irq_b;

    multi_edge_detect #(.CH(CH), .SYNC_STAGES(S), .DEBOUNCE_CYC(DA)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .signal   (sig_a),
        .en_pos   (en_pos_a),
        .en_neg   (en_neg_a),
        .clr      (clr_a),
        .level    (lvl_a),
        .pos_edge (pos_a),
        .neg_edge (neg_a),
        .pending  (pend_a),
        .irq      (irq_a)
    );

    multi_edge_detect #(.CH(CH), .SYNC_STAGES(S), .DEBOUNCE_CYC(DB)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .signal   (sig_b),
        .en_pos   (en_pos_b),
        .en_neg   (en_neg_b),
        .clr      (clr_b),
        .level    (lvl_b),
        .pos_edge (pos_b),
        .neg_edge (neg_b),
        .pending  (pend_b),
        .irq      (irq_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_chk = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    logic [31:0] sb_a[$];
    logic [31:0] sb_b[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Event word: edge index at which the pulse is registered, channel, polarity.
    function automatic logic [31:0] ev(input int c, input int ch, input logic pos);
        return {c[15:0], ch[7:0], 7'b0, pos};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge: the change is first sampled at edge cyc+1, so the pulse
    // lands on edge cyc+1+S+DEB-1.
    task automatic drive(input int dut, input logic [CH-1:0] v, input bit want);
        for (int c = 0; c < CH; c++) begin
            if (dut == 0) begin
                if (want && v[c] != sig_a[c]) sb_a.push_back(ev(cyc + S + DA, c, v[c]));
            end else begin
                if (want && v[c] != sig_b[c]) sb_b.push_back(ev(cyc + S + DB, c, v[c]));
            end
        end
        if (dut == 0) sig_a = v;
        else          sig_b = v;
    endtask

    // After reset every level is 0, so each high input becomes a fresh rising edge.
    task automatic push_release();
        for (int c = 0; c < CH; c++) begin
            if (sig_a[c]) sb_a.push_back(ev(cyc + S + DA, c, 1'b1));
            if (sig_b[c]) sb_b.push_back(ev(cyc + S + DB, c, 1'b1));
        end
    endtask

    task automatic sb_pop(input int dut, input int c, input logic pos);
        logic [31:0] e;
        if (dut == 0) begin
            chk("sb_a_expected", 32'(sb_a.size() != 0), 32'd1);
            if (sb_a.size() != 0) begin
                e = sb_a.pop_front();
                chk("sb_a_event", ev(cyc, c, pos), e);
            end
        end else begin
            chk("sb_b_expected", 32'(sb_b.size() != 0), 32'd1);
            if (sb_b.size() != 0) begin
                e = sb_b.pop_front();
                chk("sb_b_event", ev(cyc, c, pos), e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < CH; c++) begin
                if (pos_a[c] || neg_a[c]) sb_pop(0, c, pos_a[c]);
                if (pos_b[c] || neg_b[c]) sb_pop(1, c, pos_b[c]);
            end
        end
    end

    initial begin
        // Reset state
        rst = 1'b1;
        step(3);
        chk("rst_level", 32'(lvl_a), 32'h0);
        chk("rst_pos", 32'(pos_a), 32'h0);
        chk("rst_neg", 32'(neg_a), 32'h0);
        chk("rst_pend", 32'(pend_a), 32'h0);
        chk("rst_irq", 32'(irq_a), 32'h0);
        chk("rst_level_b", 32'(lvl_b), 32'h0);
        rst    = 1'b0;
        mon_en = 1'b1;
        step(2);

        // Single rising edge, no filtering: pulse then pending one cycle later
        drive(0, 4'b0001, 1'b1);
        step(3);
        chk("t1_level", 32'(lvl_a[0]), 32'h1);
        chk("t1_pend_lag", 32'(pend_a[0]), 32'h0);
        step(1);
        chk("t1_pend", 32'(pend_a[0]), 32'h1);
        chk("t1_irq", 32'(irq_a), 32'h1);
        clr_a = 4'b0001;
        step(1);
        clr_a = 4'b0000;
        chk("t1_clr", 32'(pend_a[0]), 32'h0);
        chk("t1_irq_clr", 32'(irq_a), 32'h0);

        // Debounce 4: a 3-cycle glitch is filtered, a 4-cycle pulse is accepted
        drive(1, 4'b0010, 1'b0);
        step(3);
        drive(1, 4'b0000, 1'b0);
        step(8);
        chk("t2_glitch_level", 32'(lvl_b[1]), 32'h0);
        drive(1, 4'b0010, 1'b1);
        step(4);
        drive(1, 4'b0000, 1'b1);
        step(12);
        chk("t2_level_back", 32'(lvl_b[1]), 32'h0);

        // Only falling edges of channel 2 may set pending
        en_pos_a[2] = 1'b0;
        drive(0, 4'b0101, 1'b1);
        step(5);
        chk("t3_rise_masked", 32'(pend_a[2]), 32'h0);
        step(5);
        drive(0, 4'b0001, 1'b1);
        step(5);
        chk("t3_fall_sets", 32'(pend_a[2]), 32'h1);
        clr_a = 4'b0100;
        step(1);
        clr_a = 4'b0000;
        chk("t3_clr", 32'(pend_a), 32'h0);

        // Set wins over a simultaneous clear; enable changes keep existing flags
        drive(0, 4'b1001, 1'b1);
        step(4);
        chk("t4_pend_rise", 32'(pend_a[3]), 32'h1);
        drive(0, 4'b0001, 1'b1);
        step(3);
        clr_a = 4'b1000;
        step(1);
        clr_a = 4'b0000;
        chk("t4_set_wins", 32'(pend_a[3]), 32'h1);
        en_neg_a = 4'b0000;
        step(1);
        chk("t4_en_keeps", 32'(pend_a[3]), 32'h1);
        en_neg_a = 4'b1111;
        clr_a    = 4'b1000;
        step(1);
        clr_a = 4'b0000;
        chk("t4_clr", 32'(pend_a[3]), 32'h0);
        chk("t4_irq", 32'(irq_a), 32'h0);

        // All channels rise together
        drive(0, 4'b0000, 1'b1);
        step(5);
        clr_a = 4'b1111;
        step(1);
        clr_a = 4'b0000;
        chk("t5_clear_all", 32'(pend_a), 32'h0);
        en_pos_a = 4'b1111;
        drive(0, 4'b1111, 1'b1);
        step(3);
        chk("t5_pos_all", 32'(pos_a), 32'hF);
        step(1);
        chk("t5_pend_all", 32'(pend_a), 32'hF);
        chk("t5_irq", 32'(irq_a), 32'h1);

        // Reset in the middle of a debounce window, inputs held high throughout
        drive(1, 4'b1111, 1'b0);
        step(3);
        rst = 1'b1;
        step(2);
        chk("t6_rst_level", 32'(lvl_a), 32'h0);
        chk("t6_rst_pos", 32'(pos_a), 32'h0);
        chk("t6_rst_neg", 32'(neg_a), 32'h0);
        chk("t6_rst_pend", 32'(pend_a), 32'h0);
        chk("t6_rst_irq", 32'(irq_a), 32'h0);
        chk("t6_rst_level_b", 32'(lvl_b), 32'h0);
        chk("t6_rst_pend_b", 32'(pend_b), 32'h0);
        rst = 1'b0;
        push_release();
        step(3);
        chk("t6_pos_a", 32'(pos_a), 32'hF);
        step(3);
        chk("t6_pos_b", 32'(pos_b), 32'hF);
        step(2);
        chk("t6_pend_a", 32'(pend_a), 32'hF);
        step(10);

        chk("sb_a_drained", 32'(sb_a.size()), 32'd0);
        chk("sb_b_drained", 32'(sb_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
